// File: rtl/uart_tx.sv
// uart_tx: bus-attached 8N1 UART transmitter. Bytes written to DATA are queued
// in a small circular FIFO and shifted out LSB first on a registered tx line.
// STATUS exposes overrun, busy and transmit-ready; o_int pulses once when the
// line drains with nothing left to send.
module uart_tx #(
  parameter int SYS_CLK    = 25_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [7:0] i_dat,
  output logic [7:0] o_dat,
  input  logic       i_addr,
  input  logic       i_we,
  input  logic       i_cyc,
  output logic       tx,
  output logic       o_int
);

  // Bit period in clock cycles; the baud counter runs 0..TICK-1 within each bit.
  localparam int          TICK      = SYS_CLK / BAUDRATE;
  localparam logic [11:0] TICK_LAST = 12'(TICK - 1);

  // FIFO pointers carry one extra wrap bit so full and empty can be told apart.
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Frame sequencer states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // FIFO storage and pointers.
  logic [7:0]  mem_r [FIFO_DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;

  // Sequencer registers.
  logic [1:0]  state_r;
  logic [11:0] cnt_r;
  logic [2:0]  idx_r;
  logic [7:0]  shift_r;
  logic        tx_r;
  logic        done_r;
  logic        int_r;
  logic        ov_r;

  // Combinational decode and next-state values.
  logic        empty_s;
  logic        full_s;
  logic        wr_data_s;
  logic        rd_status_s;
  logic        push_s;
  logic        overflow_s;
  logic        pop_s;
  logic        done_s;
  logic        bit_end_s;
  logic        busy_s;
  logic        line_s;
  logic [7:0]  head_s;
  logic [1:0]  state_nx_s;
  logic [11:0] cnt_nx_s;
  logic [2:0]  idx_nx_s;
  logic [7:0]  shift_nx_s;

  assign empty_s     = (wr_ptr_r == rd_ptr_r);
  assign full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign wr_data_s   = i_cyc & i_we & ~i_addr;
  assign rd_status_s = i_cyc & ~i_we & i_addr;
  // Fullness is taken before any same-cycle pop, so a write while full is lost.
  assign push_s      = wr_data_s & ~full_s;
  assign overflow_s  = wr_data_s & full_s;
  assign head_s      = mem_r[rd_ptr_r[AW-1:0]];
  assign bit_end_s   = (cnt_r == TICK_LAST);
  // done_r covers the last stop-bit cycle, which is still on the registered
  // line for one cycle after the sequencer has returned to IDLE.
  assign busy_s      = (state_r != ST_IDLE) || !empty_s || done_r;

  assign tx    = tx_r;
  assign o_int = int_r;

  // FIFO write and read pointers; push and pop may both happen in one cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // FIFO storage; contents are meaningless while the pointers say empty.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= i_dat;
    end
  end

  // Next-state, baud timing and shift-register load for the frame sequencer.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    idx_nx_s   = idx_r;
    shift_nx_s = shift_r;
    pop_s      = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nx_s = 12'd0;
        idx_nx_s = 3'd0;
        if (!empty_s) begin
          pop_s      = 1'b1;
          shift_nx_s = head_s;
          state_nx_s = ST_START;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          cnt_nx_s   = 12'd0;
          idx_nx_s   = 3'd0;
          state_nx_s = ST_DATA;
        end else begin
          cnt_nx_s = cnt_r + 12'd1;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_nx_s = 12'd0;
          if (idx_r == 3'd7) begin
            idx_nx_s   = 3'd0;
            state_nx_s = ST_STOP;
          end else begin
            idx_nx_s   = idx_r + 3'd1;
            state_nx_s = ST_DATA;
          end
        end else begin
          cnt_nx_s = cnt_r + 12'd1;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          cnt_nx_s = 12'd0;
          if (!empty_s) begin
            // Chain straight into the next start bit with no idle gap.
            pop_s      = 1'b1;
            shift_nx_s = head_s;
            state_nx_s = ST_START;
          end else begin
            done_s     = 1'b1;
            state_nx_s = ST_IDLE;
          end
        end else begin
          cnt_nx_s = cnt_r + 12'd1;
        end
      end
      default: begin
        cnt_nx_s   = 12'd0;
        idx_nx_s   = 3'd0;
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Line level implied by the current sequencer state.
  always_comb begin
    line_s = 1'b1;
    case (state_r)
      ST_START: line_s = 1'b0;
      ST_DATA:  line_s = shift_r[idx_r];
      default:  line_s = 1'b1;
    endcase
  end

  // Sequencer state, registered tx line and the drain interrupt pipeline.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 12'd0;
      idx_r   <= 3'd0;
      shift_r <= 8'd0;
      tx_r    <= 1'b1;
      done_r  <= 1'b0;
      int_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      idx_r   <= idx_nx_s;
      shift_r <= shift_nx_s;
      tx_r    <= line_s;
      // o_int lines up with tx: it rises as the stop bit leaves the line.
      done_r  <= done_s;
      int_r   <= done_r;
    end
  end

  // Overrun flag: set by a dropped write, cleared by a STATUS read unless a
  // write is dropped on the same edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ov_r <= 1'b0;
    end else if (overflow_s) begin
      ov_r <= 1'b1;
    end else if (rd_status_s) begin
      ov_r <= 1'b0;
    end else begin
      ov_r <= ov_r;
    end
  end

  // Bus read data; DATA reads return zero.
  always_comb begin
    o_dat = 8'd0;
    if (rd_status_s) begin
      o_dat = {5'd0, ov_r, busy_s, ~full_s};
    end else begin
      o_dat = 8'd0;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with TICK = 10 and a 4-deep FIFO.
// A line decoder turns tx back into bytes and frame start times; expected
// bytes are kept in a queue and timing is derived from the frame arithmetic.
module tb_uart_tx;

  localparam int TICK  = 10;
  localparam int FRAME = 10 * TICK;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] wdat;
  logic [7:0] rdat;
  logic       addr;
  logic       we;
  logic       cyc;
  logic       tx;
  logic       irq;

  int cyc_cnt = 0;
  int n_cmp   = 0;
  int n_fail  = 0;

  logic [7:0] rx_q[$];
  int         fs_q[$];
  int         int_q[$];
  logic       int_tx_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic       cyc;
    logic       we;
    logic       addr;
    logic [7:0] dat;
    logic       chk;
    logic [7:0] exp_dat;
    logic       exp_tx;
    logic       exp_int;
  } vec_t;

  vec_t vecs[10];

  uart_tx #(
    .SYS_CLK   (1_000_000),
    .BAUDRATE  (100_000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(reset_n),
    .i_dat    (wdat),
    .o_dat    (rdat),
    .i_addr   (addr),
    .i_we     (we),
    .i_cyc    (cyc),
    .tx       (tx),
    .o_int    (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic c, input logic w, input logic a, input logic [7:0] d);
    cyc  = c;
    we   = w;
    addr = a;
    wdat = d;
  endtask

  task automatic write_data(input logic [7:0] b, output int acc);
    bus(1'b1, 1'b1, 1'b0, b);
    tick();
    acc = cyc_cnt;
    bus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic read_status(output logic [7:0] v);
    bus(1'b1, 1'b0, 1'b1, 8'h00);
    @(negedge clk);
    v = rdat;
    tick();
    bus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_q();
    rx_q.delete();
    fs_q.delete();
    int_q.delete();
    int_tx_q.delete();
    exp_q.delete();
  endtask

  // Waits (bounded) for every expected byte, lets the line settle, then
  // compares the decoded stream with the expected queue.
  task automatic compare_rx(input string name);
    int n;
    int t;
    n = exp_q.size();
    t = 0;
    while (rx_q.size() < n && t < n * FRAME + 400) begin
      tick();
      t++;
    end
    repeat (150) tick();
    check({name, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < rx_q.size()) check($sformatf("%s_byte%0d", name, i), rx_q[i], exp_q[i]);
    end
  endtask

  // Line decoder: a low level seen while idle starts a frame of FRAME samples.
  initial begin : line_monitor
    logic [9:0] bits;
    logic       glitch;
    logic       aborted;
    int         f;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && tx === 1'b0) begin
        f       = cyc_cnt;
        bits    = 10'd0;
        glitch  = 1'b0;
        aborted = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
          if (k > 0) @(negedge clk);
          if (reset_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (k % TICK == 0) bits[k / TICK] = tx;
          else if (tx !== bits[k / TICK]) glitch = 1'b1;
        end
        if (!aborted) begin
          check("bit_steady", glitch, 1'b0);
          check("stop_bit", bits[9], 1'b1);
          rx_q.push_back(bits[8:1]);
          fs_q.push_back(f);
        end
      end
    end
  end

  // Interrupt log: cycle of each o_int sample and the line level at that time.
  always @(negedge clk) begin
    if (irq === 1'b1) begin
      int_q.push_back(cyc_cnt);
      int_tx_q.push_back(tx);
    end
  end

  initial begin : main
    int         acc;
    int         acc0;
    int         t;
    logic [7:0] st;
    logic [7:0] b;

    // Register-access vectors from idle: {cyc, we, addr, dat, chk, exp_dat, exp_tx, exp_int}.
    vecs[0] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0}; // STATUS idle
    vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0}; // DATA read
    vecs[2] = '{1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0}; // STATUS write ignored
    vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0}; // no cycle, no push
    vecs[5] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0}; // write accepted at E
    vecs[7] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h03, 1'b1, 1'b0}; // queued, busy
    vecs[8] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h03, 1'b1, 1'b0}; // START, FIFO empty
    vecs[9] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0}; // tx low after E+2

    // Reset state.
    reset_n = 1'b0;
    bus(1'b1, 1'b0, 1'b1, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_int", irq, 1'b0);
    check("rst_status", rdat, 8'h01);
    reset_n = 1'b1;
    bus(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (3) tick();

    // Table-driven register access.
    clear_q();
    for (int i = 0; i < 10; i++) begin
      bus(vecs[i].cyc, vecs[i].we, vecs[i].addr, vecs[i].dat);
      @(negedge clk);
      if (vecs[i].chk) check($sformatf("vec%0d_odat", i), rdat, vecs[i].exp_dat);
      check($sformatf("vec%0d_tx", i), tx, vecs[i].exp_tx);
      check($sformatf("vec%0d_int", i), irq, vecs[i].exp_int);
      tick();
    end
    bus(1'b0, 1'b0, 1'b0, 8'h00);
    exp_q.push_back(8'h5A);
    compare_rx("vec_frame");

    // Single byte: timing of the falling edge, interrupt and BUSY.
    clear_q();
    write_data(8'hA5, acc);
    exp_q.push_back(8'hA5);
    repeat (50) tick();
    read_status(st);
    check("single_busy_mid", st[1], 1'b1);
    compare_rx("single");
    check("single_frames", fs_q.size(), 1);
    if (fs_q.size() > 0) check("single_fall_delay", fs_q[0] - acc, 2);
    check("single_int_count", int_q.size(), 1);
    if (int_q.size() > 0 && fs_q.size() > 0) begin
      check("single_int_time", int_q[0] - fs_q[0], FRAME);
      check("single_int_tx", int_tx_q[0], 1'b1);
    end
    read_status(st);
    check("single_status_end", st, 8'h01);

    // Back-to-back frames.
    clear_q();
    write_data(8'h00, acc);
    write_data(8'hFF, acc);
    write_data(8'h55, acc);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    compare_rx("b2b");
    check("b2b_int_count", int_q.size(), 1);
    if (fs_q.size() == 3) begin
      check("b2b_gap1", fs_q[1] - fs_q[0], FRAME);
      check("b2b_gap2", fs_q[2] - fs_q[1], FRAME);
      if (int_q.size() > 0) check("b2b_int_time", int_q[0] - fs_q[2], FRAME);
    end

    // Overrun: the first byte leaves the FIFO at once, so DEPTH+1 bytes fit.
    clear_q();
    for (int i = 0; i < 6; i++) begin
      b = 8'h10 + 8'(i);
      write_data(b, acc);
      if (i < DEPTH + 1) exp_q.push_back(b);
    end
    read_status(st);
    check("ovr_status1", st, 8'h06);
    read_status(st);
    check("ovr_status2", st, 8'h02);
    compare_rx("ovr");
    check("ovr_int_count", int_q.size(), 1);

    // Write while full on the same edge as the STOP pop: START at E+1, ten bits.
    clear_q();
    write_data(8'hA0, acc0);
    for (int i = 1; i < 5; i++) write_data(8'hA0 + 8'(i), acc);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'hA0 + 8'(i));
    while (cyc_cnt < acc0 + FRAME - 1) tick();
    read_status(st);
    check("simul_full", st, 8'h02);
    write_data(8'hEE, acc);
    read_status(st);
    check("simul_after", st, 8'h07);
    compare_rx("simul");

    // Wrap-around: stream 0x01..0x14, writing whenever TXR is set.
    clear_q();
    for (int i = 1; i <= 20; i++) begin
      read_status(st);
      check($sformatf("wrap_ov%0d", i), st[2], 1'b0);
      t = 0;
      while (!st[0] && t < 400) begin
        read_status(st);
        t++;
      end
      check($sformatf("wrap_txr%0d", i), st[0], 1'b1);
      write_data(8'(i), acc);
      exp_q.push_back(8'(i));
    end
    compare_rx("wrap");

    // Random bytes, random gaps and DATA reads.
    clear_q();
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        bus(1'b1, 1'b0, 1'b0, 8'($urandom));
        @(negedge clk);
        check("rand_data_read", rdat, 8'h00);
        tick();
        bus(1'b0, 1'b0, 1'b0, 8'h00);
      end
      t = 0;
      read_status(st);
      while (!st[0] && t < 400) begin
        read_status(st);
        t++;
      end
      check("rand_txr", st[0], 1'b1);
      write_data(b, acc);
      exp_q.push_back(b);
      repeat ($urandom_range(0, 120)) tick();
    end
    compare_rx("rand");
    read_status(st);
    check("rand_status_end", st, 8'h01);

    // Reset during data bit 3 with two bytes still queued.
    clear_q();
    write_data(8'h11, acc0);
    write_data(8'h22, acc);
    write_data(8'h33, acc);
    while (cyc_cnt < acc0 + 2 + 4 * TICK + 5) tick();
    reset_n = 1'b0;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_int", irq, 1'b0);
    bus(1'b1, 1'b0, 1'b1, 8'h00);
    #1;
    check("midrst_status", rdat, 8'h01);
    repeat (3) tick();
    reset_n = 1'b1;
    bus(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (300) tick();
    check("midrst_no_frames", rx_q.size(), 0);
    check("midrst_no_int", int_q.size(), 0);
    read_status(st);
    check("midrst_status_after", st, 8'h01);
    clear_q();
    write_data(8'h3C, acc);
    exp_q.push_back(8'h3C);
    compare_rx("midrst_new");
    check("midrst_new_int", int_q.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
